// File: rtl/microcode_sequencer_pkg.sv
// Shared types for the microcode sequencer.
//   instr_length : decoded instruction cycle class (CYCLE5/CYCLE7/CYCLE12)
//   seq_state    : sequencer FSM states
//   INT_CYCLES   : length of the interrupt-entry sequence in CPU cycles
//   exec_steps() : number of microcode EXEC steps for an instruction length
package microcode_sequencer_pkg;

    typedef enum logic [1:0] {
        CYCLE5,
        CYCLE7,
        CYCLE12
    } instr_length;

    typedef enum logic [2:0] {
        SEQ_FETCH,
        SEQ_DECODE,
        SEQ_EXEC,
        SEQ_INT,
        SEQ_HALT
    } seq_state;

    localparam int unsigned INT_CYCLES = 12;

    // Fetch and decode take one cycle each, so EXEC covers the remainder.
    function automatic logic [3:0] exec_steps(input instr_length len);
        case (len)
            CYCLE5:  exec_steps = 4'd3;
            CYCLE7:  exec_steps = 4'd5;
            CYCLE12: exec_steps = 4'd10;
            default: exec_steps = 4'd3;
        endcase
    endfunction

endpackage

// File: rtl/microcode_sequencer.sv
// Instruction timing sequencer: steps fetch, decode and execute cycles, walks
// microcode ROM addresses, and arbitrates interrupt entry and HALT at
// instruction boundaries. Two clk_2x_en ticks (phase 0, phase 1) make one CPU
// cycle; all state holds when clk_2x_en is low.
//   clk, reset            : core clock, synchronous active-high reset
//   clk_2x_en             : tick enable
//   microcode_start_addr,
//   cycle_length,
//   skip_pc_increment,
//   disable_interrupt     : registered decoder outputs
//   halt_req              : HALT/SLP request from microcode
//   interrupt_req/_enable : pending interrupt level and I flag
//   fetch_en, pc_increment,
//   instr_done, interrupt_ack : one-clk pulses
//   microcode_addr/_valid/_phase : ROM address {slot, step}, valid, phase
//   halted                : high while in HALT
module microcode_sequencer
    import microcode_sequencer_pkg::*;
#(
    parameter logic [6:0]  INT_START_ADDR = 7'd98,
    parameter int unsigned STEP_BITS      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_2x_en,
    input  logic [6:0]             microcode_start_addr,
    input  instr_length            cycle_length,
    input  logic                   skip_pc_increment,
    input  logic                   disable_interrupt,
    input  logic                   halt_req,
    input  logic                   interrupt_req,
    input  logic                   interrupt_enable,
    output logic                   fetch_en,
    output logic                   pc_increment,
    output logic [6+STEP_BITS:0]   microcode_addr,
    output logic                   microcode_valid,
    output logic                   microcode_phase,
    output logic                   instr_done,
    output logic                   interrupt_ack,
    output logic                   halted
);

    localparam logic [STEP_BITS-1:0] IntLast  = STEP_BITS'(INT_CYCLES - 1);
    // The first two interrupt cycles are idle before the ROM routine runs.
    localparam logic [STEP_BITS-1:0] IntIdle  = STEP_BITS'(2);

    seq_state             state_q, state_d;
    logic                 phase_q;
    logic [STEP_BITS-1:0] step_q, step_d;
    logic [STEP_BITS-1:0] nsteps_q, nsteps_d;
    logic [6:0]           slot_q, slot_d;
    logic                 inhibit_q, inhibit_d;
    logic                 skip_q, skip_d;
    logic                 halt_pend_q, halt_pend_d;
    logic                 fetch_d, pcinc_d, done_d, ack_d;
    logic                 halt_seen;
    logic [STEP_BITS-1:0] int_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEQ_FETCH;
            phase_q      <= 1'b0;
            step_q       <= '0;
            nsteps_q     <= '0;
            slot_q       <= '0;
            inhibit_q    <= 1'b0;
            skip_q       <= 1'b0;
            halt_pend_q  <= 1'b0;
            fetch_en     <= 1'b0;
            pc_increment <= 1'b0;
            instr_done   <= 1'b0;
            interrupt_ack <= 1'b0;
        end else begin
            // Pulses last exactly one clk regardless of the enable.
            fetch_en      <= clk_2x_en & fetch_d;
            pc_increment  <= clk_2x_en & pcinc_d;
            instr_done    <= clk_2x_en & done_d;
            interrupt_ack <= clk_2x_en & ack_d;
            if (clk_2x_en) begin
                state_q     <= state_d;
                phase_q     <= ~phase_q;
                step_q      <= step_d;
                nsteps_q    <= nsteps_d;
                slot_q      <= slot_d;
                inhibit_q   <= inhibit_d;
                skip_q      <= skip_d;
                halt_pend_q <= halt_pend_d;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        nsteps_d    = nsteps_q;
        slot_d      = slot_q;
        inhibit_d   = inhibit_q;
        skip_d      = skip_q;
        halt_pend_d = halt_pend_q;
        fetch_d     = 1'b0;
        pcinc_d     = 1'b0;
        done_d      = 1'b0;
        ack_d       = 1'b0;
        // A request on the final EXEC tick still counts for this boundary.
        halt_seen   = halt_pend_q | halt_req;

        unique case (state_q)
            SEQ_FETCH: begin
                if (!phase_q) fetch_d = 1'b1;
                else          state_d = SEQ_DECODE;
            end
            SEQ_DECODE: begin
                if (!phase_q) begin
                    slot_d      = microcode_start_addr;
                    nsteps_d    = STEP_BITS'(exec_steps(cycle_length));
                    inhibit_d   = disable_interrupt;
                    skip_d      = skip_pc_increment;
                    halt_pend_d = 1'b0;
                end else begin
                    pcinc_d = ~skip_q;
                    step_d  = '0;
                    state_d = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                halt_pend_d = halt_seen;
                if (phase_q) begin
                    if (step_q == nsteps_q - 1'b1) begin
                        done_d      = 1'b1;
                        inhibit_d   = 1'b0;
                        halt_pend_d = 1'b0;
                        step_d      = '0;
                        if (interrupt_req && interrupt_enable && !inhibit_q) begin
                            state_d = SEQ_INT;
                        end else if (halt_seen) begin
                            state_d = SEQ_HALT;
                        end else begin
                            state_d = SEQ_FETCH;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            SEQ_INT: begin
                // step_q counts interrupt cycles here, not ROM steps.
                if (!phase_q && step_q == '0) ack_d = 1'b1;
                if (phase_q) begin
                    if (step_q == IntLast) begin
                        step_d  = '0;
                        state_d = SEQ_FETCH;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            SEQ_HALT: begin
                if (phase_q && interrupt_req) begin
                    step_d  = '0;
                    state_d = interrupt_enable ? SEQ_INT : SEQ_FETCH;
                end
            end
            default: state_d = SEQ_FETCH;
        endcase
    end

    assign int_step        = step_q - IntIdle;
    assign microcode_phase = phase_q;
    assign halted          = (state_q == SEQ_HALT);
    assign microcode_valid = (state_q == SEQ_EXEC) ||
                             ((state_q == SEQ_INT) && (step_q >= IntIdle));

    always_comb begin
        microcode_addr = '0;
        if (state_q == SEQ_EXEC) begin
            microcode_addr = {slot_q, step_q};
        end else if (state_q == SEQ_INT && step_q >= IntIdle) begin
            microcode_addr = {INT_START_ADDR, int_step};
        end
    end

endmodule
